// File: rtl/result_drain_pkg.sv
// Shared definitions for the result drain block.
// Holds the default buffer geometry, the matrix dimension width, the FSM
// state encoding and a helper that forms the job size from the dimensions.
package result_drain_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DIM_W      = 10;
    localparam int IDX_W      = 2 * DIM_W;
    localparam int WADDR_W    = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    // Number of result words in an m x n job.
    function automatic logic [IDX_W-1:0] job_total(input logic [DIM_W-1:0] m,
                                                    input logic [DIM_W-1:0] n);
        return IDX_W'(m) * IDX_W'(n);
    endfunction

endpackage

// File: rtl/result_drain_if.sv
// Bus bundle between the matrix multiplier, the result drain and the
// downstream consumer.
//   wr_en/wr_addr/wr_data : result word writes from the multiplier
//   m/n/mm_done           : job dimensions and job-complete indication
//   out_*                 : valid/ready stream of result words, row-major
//   drained/err           : end-of-job pulse and sticky error flag
// slave  : the drain block side
// master : the multiplier/consumer (testbench) side
interface result_drain_if #(
    parameter int DATA_W = result_drain_pkg::DEF_DATA_W
) ();
    import result_drain_pkg::*;

    logic               wr_en;
    logic [WADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [DIM_W-1:0]   m;
    logic [DIM_W-1:0]   n;
    logic               mm_done;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [DIM_W-1:0]   out_row;
    logic [DIM_W-1:0]   out_col;
    logic               out_last;
    logic               drained;
    logic               err;

    modport slave (
        input  wr_en, wr_addr, wr_data, m, n, mm_done, out_ready,
        output out_valid, out_data, out_row, out_col, out_last, drained, err
    );

    modport master (
        output wr_en, wr_addr, wr_data, m, n, mm_done, out_ready,
        input  out_valid, out_data, out_row, out_col, out_last, drained, err
    );

endinterface

// File: rtl/result_drain_ram.sv
// Single-port result buffer with one cycle of read latency.
// Ports:
//   clk      : clock
//   i_we     : write enable for i_addr
//   i_addr   : shared read/write address
//   i_wdata  : write data
//   o_rdata  : word at the address of the previous cycle (read-before-write)
// Contents are deliberately not reset.
module result_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/result_drain.sv
// Collects multiplier result words into a buffer, then streams them out
// row-major on a valid/ready port once the multiplier reports completion.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : result_drain_if slave (writes, job start, output stream, status)
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | accept result writes, wait for mm_done
// RD      | drive buffer address for the current index
// WAIT    | capture buffer read data and the last-beat flag
// HOLD    | out_valid high until the consumer takes the word
// FIN     | one-cycle drained pulse, write count cleared
module result_drain
    import result_drain_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    result_drain_if.slave  bus
);

    localparam int          CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_total;
    logic [DIM_W-1:0]  r_n;
    logic [DIM_W-1:0]  r_row;
    logic [DIM_W-1:0]  r_col;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_err;

    logic              w_idle;
    logic              w_wr_in_range;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [IDX_W-1:0]  w_total;
    logic              w_job_err;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_wr_in_range = (32'(bus.wr_addr) < DEPTH);
    assign w_ram_we      = w_idle && bus.wr_en && w_wr_in_range;
    // The index is truncated to the buffer width, so oversize jobs wrap.
    assign w_ram_addr    = w_idle ? bus.wr_addr[ADDR_W-1:0] : r_idx[ADDR_W-1:0];
    assign w_total       = job_total(bus.m, bus.n);
    assign w_job_err     = (32'(r_wr_cnt) != 32'(w_total)) || (32'(w_total) > DEPTH);

    result_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (bus.wr_data),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wr_cnt <= '0;
            r_idx    <= '0;
            r_total  <= '0;
            r_n      <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ram_we && (r_wr_cnt != CNT_MAX)) begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                    end
                    if (bus.wr_en && !w_wr_in_range) begin
                        r_err <= 1'b1;
                    end
                    if (bus.mm_done) begin
                        r_n     <= bus.n;
                        r_total <= w_total;
                        r_idx   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        // Starting a job clears err, then re-evaluates it.
                        r_err   <= w_job_err || (bus.wr_en && !w_wr_in_range);
                        r_state <= (w_total == '0) ? ST_FIN : ST_RD;
                    end
                end
                ST_RD: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_data  <= w_ram_rdata;
                    r_last  <= (r_idx == r_total - IDX_W'(1));
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_last <= 1'b0;
                        if (r_last) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            if (r_col == r_n - DIM_W'(1)) begin
                                r_col <= '0;
                                r_row <= r_row + DIM_W'(1);
                            end else begin
                                r_col <= r_col + DIM_W'(1);
                            end
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_FIN: begin
                    r_wr_cnt <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Writes arriving while a drain is running are dropped.
            if (bus.wr_en && !w_idle) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_data  = r_data;
    assign bus.out_row   = r_row;
    assign bus.out_col   = r_col;
    assign bus.out_last  = r_last;
    assign bus.drained   = (r_state == ST_FIN);
    assign bus.err       = r_err;

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;
    import result_drain_pkg::*;

    localparam int ADDR_W = DEF_ADDR_W;
    localparam int DATA_W = DEF_DATA_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_drain_if #(.DATA_W(DATA_W)) bus ();

    result_drain #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the buffer should hold, and which words are known.
    logic [DATA_W-1:0] mdl_mem [DEPTH];
    bit                mdl_ok  [DEPTH];

    typedef struct {
        int m;
        int n;
        int n_wr;
        bit bad;
        int ready_pct;
        bit exp_err;
    } job_t;

    job_t jobs [10];

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    task automatic wr_word(input int addr, input logic [DATA_W-1:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 16'(addr);
        bus.wr_data = data;
        if (addr < DEPTH) begin
            mdl_mem[addr] = data;
            mdl_ok[addr]  = 1'b1;
        end
    endtask

    task automatic wr_end();
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Starts a job and follows it to the drained pulse, checking every beat
    // against the model: word k is buffer[k mod depth] at row k/n, col k%n.
    task automatic drain(input int m, input int n, input bit exp_err, input int ready_pct,
                         input int stall_k, input int stall_len, input int inj_cycle);
        int total, k, cyc, last_cyc, stall_left;
        bit prev_hold, done, injected, rdy, seen_valid;
        logic [DATA_W-1:0] p_data;
        logic [DIM_W-1:0]  p_row, p_col;
        logic              p_last;
        total = m * n; k = 0; cyc = 0; last_cyc = -1; stall_left = stall_len;
        prev_hold = 0; done = 0; injected = 0; rdy = 0; seen_valid = 0;
        p_data = '0; p_row = '0; p_col = '0; p_last = 1'b0;
        @(negedge clk);
        bus.m = DIM_W'(m); bus.n = DIM_W'(n); bus.mm_done = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.mm_done = 1'b0;
        cyc = 1;
        while (!done && cyc < 20000) begin
            bus.wr_en = 1'b0;
            if (cyc == 1) chk("err_after_start", bus.err, exp_err);
            if (bus.drained) begin
                chk("drained_beats", k, total);
                chk("drained_valid_low", bus.out_valid, 0);
                chk("drained_latency", cyc, (total == 0) ? 1 : last_cyc + 1);
                chk("err_at_drained", bus.err, exp_err | injected);
                done = 1;
            end else begin
                if (cyc == inj_cycle) begin
                    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = DATA_W'(32'hDEAD_BEEF);
                    injected = 1;
                end
                if (prev_hold) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_data", bus.out_data, p_data);
                    chk("hold_row", bus.out_row, p_row);
                    chk("hold_col", bus.out_col, p_col);
                    chk("hold_last", bus.out_last, p_last);
                end
                if (bus.out_valid) begin
                    if (!seen_valid) chk("first_valid_latency", cyc, 3);
                    seen_valid = 1;
                    if (k >= total) begin
                        chk("extra_beat", bus.out_valid, 0);
                        rdy = 1;
                    end else begin
                        rdy = ($urandom_range(99) < ready_pct);
                        if (k == stall_k && stall_left > 0) begin
                            rdy = 0;
                            stall_left--;
                        end
                    end
                    bus.out_ready = rdy;
                    if (rdy && k < total) begin
                        if (mdl_ok[k % DEPTH]) chk("beat_data", bus.out_data, mdl_mem[k % DEPTH]);
                        chk("beat_row", bus.out_row, k / n);
                        chk("beat_col", bus.out_col, k % n);
                        chk("beat_last", bus.out_last, (k == total - 1) ? 1 : 0);
                        if (ready_pct >= 100 && stall_len == 0 && last_cyc >= 0)
                            chk("beat_spacing", cyc - last_cyc, 3);
                        last_cyc = cyc;
                        k++;
                    end
                    prev_hold = !rdy;
                    p_data = bus.out_data; p_row = bus.out_row;
                    p_col = bus.out_col;   p_last = bus.out_last;
                end else begin
                    bus.out_ready = 1'($urandom_range(1));
                    prev_hold = 0;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.wr_en = 1'b0;
        bus.out_ready = 1'b0;
        chk("drain_completed", done, 1);
        @(negedge clk);
        chk("drained_one_cycle", bus.drained, 0);
        chk("idle_valid_low", bus.out_valid, 0);
    endtask

    task automatic run_job(input job_t j);
        for (int i = 0; i < j.n_wr; i++) wr_word(i % DEPTH, DATA_W'($urandom));
        if (j.bad) wr_word(DEPTH, DATA_W'($urandom));
        wr_end();
        if (j.bad) chk("bad_addr_sets_err", bus.err, 1);
        drain(j.m, j.n, j.exp_err, j.ready_pct, -1, 0, -1);
    endtask

    initial begin
        int cyc;
        bit saw;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.m = '0; bus.n = '0; bus.mm_done = 1'b0; bus.out_ready = 1'b0;

        //           m   n   n_wr  bad  ready  err
        jobs[0] = '{ 2,  2,     4,   0,   100,   0};
        jobs[1] = '{ 2,  2,     3,   0,   100,   1};
        jobs[2] = '{ 1,  3,     3,   0,    50,   0};
        jobs[3] = '{ 0,  5,     0,   0,   100,   0};
        jobs[4] = '{ 5,  0,     2,   0,   100,   1};
        jobs[5] = '{ 3,  1,     3,   0,    30,   0};
        jobs[6] = '{ 2,  3,     6,   1,    70,   0};
        jobs[7] = '{ 1,  1,     2,   0,   100,   1};
        jobs[8] = '{33, 32,  1024,   0,   100,   1};
        jobs[9] = '{32, 32,  1025,   0,   100,   0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_drained", bus.drained, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_row", bus.out_row, 0);
        chk("rst_out_col", bus.out_col, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Scenario 1: 2x2 job, consumer always ready
        wr_word(0, 19); wr_word(1, 22); wr_word(2, 43); wr_word(3, 50);
        wr_end();
        drain(2, 2, 0, 100, -1, 0, -1);

        // Scenario 2: same data, second beat stalled for 5 cycles
        wr_word(0, 19); wr_word(1, 22); wr_word(2, 43); wr_word(3, 50);
        wr_end();
        drain(2, 2, 0, 100, 1, 5, -1);

        // Scenario 3: empty job
        drain(0, 5, 0, 100, -1, 0, -1);

        // Scenario 4: short write count, plus a write during the drain
        for (int i = 0; i < 3; i++) wr_word(i, DATA_W'($urandom));
        wr_end();
        drain(2, 2, 1, 100, -1, 0, 4);
        drain(1, 1, 1, 100, -1, 0, -1);   // word 0 must be untouched

        // Scenario 6: out-of-range write address
        wr_word(DEPTH, DATA_W'(32'h0BAD_0BAD));
        wr_end();
        chk("s6_err", bus.err, 1);
        drain(1, 1, 1, 100, -1, 0, -1);   // word 0 must be untouched

        // Scenario 5: reset while holding the second beat
        for (int i = 0; i < 4; i++) wr_word(i, DATA_W'($urandom));
        wr_end();
        @(negedge clk);
        bus.m = 2; bus.n = 2; bus.mm_done = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.mm_done = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        chk("s5_first_beat", bus.out_valid, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        chk("s5_second_beat", bus.out_valid, 1);
        chk("s5_second_col", bus.out_col, 1);
        rst_n = 1'b0;
        #1;
        chk("s5_async_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("s5_rst_valid", bus.out_valid, 0);
        chk("s5_rst_data", bus.out_data, 0);
        chk("s5_rst_err", bus.err, 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            saw = saw | bus.out_valid | bus.drained;
        end
        chk("s5_no_activity_after_rst", saw, 0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr_word(i, DATA_W'($urandom));
        wr_end();
        drain(1, 3, 0, 100, -1, 0, -1);

        // Table of jobs
        for (int t = 0; t < 10; t++) run_job(jobs[t]);

        // Randomised jobs
        for (int r = 0; r < 8; r++) begin
            job_t j;
            int tot;
            j.m = $urandom_range(0, 6);
            j.n = $urandom_range(0, 6);
            tot = j.m * j.n;
            j.n_wr = tot + $urandom_range(0, 2) - 1;
            if (j.n_wr < 0) j.n_wr = 0;
            j.bad = 1'($urandom_range(1));
            j.ready_pct = $urandom_range(25, 100);
            j.exp_err = (j.n_wr != tot);
            run_job(j);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter ADDR_W, default 10, result buffer address width; depth = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, result word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_en  input  1  multiplier result write strobe, one word per cycle.
REQ-006 wr_addr  input  16  row-major result index (i*n+j).
REQ-007 wr_data  input  DATA_W  result word.
REQ-008 m  input  10  result rows, sampled when mm_done is seen in IDLE.
REQ-009 n  input  10  result columns, sampled when mm_done is seen in IDLE.
REQ-010 mm_done  input  1  multiplier finished; level or pulse, acted on once per job.
REQ-011 out_valid  output  1  out_data holds a valid result word.
REQ-012 out_ready  input  1  downstream accepts the word; a beat transfers when out_valid && out_ready.
REQ-013 out_data  output  DATA_W  result word, row-major order.
REQ-014 out_row  output  10  row index of out_data.
REQ-015 out_col  output  10  column index of out_data.
REQ-016 out_last  output  1  high with the final beat (index m*n-1).
REQ-017 drained  output  1  one-cycle pulse after the final beat transfers, or after an empty job.
REQ-018 err  output  1  sticky error flag, cleared only by reset or by mm_done accepted in IDLE.

Function
REQ-019 States: IDLE, RD (issue read), WAIT (RAM latency), HOLD (out_valid asserted), FIN (drained pulse).
REQ-020 IDLE: wr_en with wr_addr < 2**ADDR_W writes wr_data to buffer; write count increments, saturating at 2**ADDR_W.
REQ-021 IDLE: wr_en with wr_addr >= 2**ADDR_W is dropped and sets err.
REQ-022 IDLE and mm_done: latch m, n; total = m*n (20-bit); clear err; if total == 0 go to FIN, else go to RD with index 0.
REQ-023 When mm_done is accepted, write count != total sets err, and the drain still proceeds over all total indices.
REQ-024 When total > 2**ADDR_W, err is set, and the drain still proceeds over all total indices; the buffer address wraps modulo depth.
REQ-025 wr_en outside IDLE is ignored and sets err.
REQ-026 Buffer is single-port synchronous-read RAM with 1-cycle read latency; RD drives the address, WAIT captures the data, HOLD presents it.
REQ-027 First out_valid appears 3 cycles after mm_done is sampled in IDLE.
REQ-028 In HOLD, out_data, out_row, out_col and out_last are stable while out_valid && !out_ready.
REQ-029 On a beat that is not last: index increments; col increments, wrapping to 0 and incrementing row at n-1; state goes to RD.
REQ-030 Sustained throughput is one beat per 3 cycles; no prefetch.
REQ-031 On the last beat, go to FIN; FIN asserts drained for exactly 1 cycle, then IDLE and write count resets to 0.
REQ-032 mm_done outside IDLE is ignored.
REQ-033 out_valid is never asserted outside HOLD.

Reset
REQ-034 While rst_n is low: state = IDLE; out_valid, out_last, drained, err = 0; out_data, out_row, out_col = 0; write count and index = 0.
REQ-035 Reset asserted mid-drain aborts the drain immediately, with no further beats and no drained pulse.
REQ-036 Buffer RAM contents are not reset.

Structure
REQ-037 A shared package holds the state encoding, the default ADDR_W and DATA_W, and the 10-bit dimension width constant.
REQ-038 One sub-module, result_ram, is a parameterised single-port synchronous-read RAM; result_drain instantiates it.

Verification
REQ-039 Scenario 1: write 2x2 words 19,22,43,50 at addr 0..3; m=2, n=2; mm_done; out_ready=1 -> 4 beats 19,22,43,50; (row,col) = (0,0),(0,1),(1,0),(1,1); out_last on 50; drained 1 cycle later; err=0.
REQ-040 Scenario 2: same data, out_ready low for 5 cycles during the beat carrying 22 -> out_data stays 22 and out_col stays 1 until accepted; no beat lost or duplicated.
REQ-041 Scenario 3: m=0, n=5; mm_done -> no out_valid; drained pulses 1 cycle after mm_done is sampled.
REQ-042 Scenario 4: 3 writes then m=2, n=2, mm_done -> err=1 and 4 beats are still emitted; a wr_en during the drain keeps err=1 and does not alter the buffer.
REQ-043 Scenario 5: rst_n low while in HOLD on the 2nd beat -> out_valid=0 on the next clk edge; then a new job of m=1, n=3 drains correctly with err=0.
REQ-044 Scenario 6: wr_en with wr_addr=1024 at ADDR_W=10 -> err=1; buffer word 0 is unchanged.
